// File: rtl/mouse_cursor_tracker.sv
// rtl/mouse_cursor_tracker.sv - relative mouse report to bounded cursor position tracker
//
// Accumulates signed mouse deltas into an absolute cursor position that is
// clamped (WRAP=0) or wrapped (WRAP=1) to the screen, with a per-frame snapshot
// of the position and registered button state with rising-edge pulses.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   report                one-cycle strobe qualifying mouse_dx/mouse_dy/mouse_btn
//   mouse_dx, mouse_dy    signed 8-bit deltas
//   mouse_btn             button levels (left, right, middle)
//   frame_tick            one-cycle frame boundary strobe
//   cur_x, cur_y          live cursor position
//   frame_x, frame_y      position captured at the last frame_tick
//   btn, btn_press        registered buttons and one-cycle rising-edge pulses
//   moved                 one-cycle pulse on every position commit
//   busy                  high while an update pass is in flight
module mouse_cursor_tracker #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int COORD_W  = 10,
    parameter int SHIFT    = 0,
    parameter int WRAP     = 0,
    parameter int INVERT_Y = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               report,
    input  logic [7:0]         mouse_dx,
    input  logic [7:0]         mouse_dy,
    input  logic [2:0]         mouse_btn,
    input  logic               frame_tick,
    output logic [COORD_W-1:0] cur_x,
    output logic [COORD_W-1:0] cur_y,
    output logic [COORD_W-1:0] frame_x,
    output logic [COORD_W-1:0] frame_y,
    output logic [2:0]         btn,
    output logic [2:0]         btn_press,
    output logic               moved,
    output logic               busy
);

    // Two guard bits above the scaled range keep every sum exact and signed.
    localparam int SW = COORD_W + SHIFT + 2;
    localparam logic signed [SW-1:0] EXT_X = SW'(SCREEN_W);
    localparam logic signed [SW-1:0] EXT_Y = SW'(SCREEN_H);

    typedef enum logic [1:0] {IDLE, SUM, BOUND} state_t;

    state_t state, state_next;

    logic [7:0] work_dx, work_dy;
    logic [7:0] pend_dx, pend_dy;
    logic       pend_flag;
    logic [2:0] btn_q;
    logic [7:0] dy_in;

    logic signed [SW-1:0] sum_x, sum_y;
    logic signed [SW-1:0] step_x, step_y, pos_x, pos_y;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {a[7], a} + {b[7], b};
        case (s[8:7])
            2'b01:   return 8'h7f;
            2'b10:   return 8'h80;
            default: return s[7:0];
        endcase
    endfunction

    // A single correction is enough because one scaled delta never exceeds the extent.
    function automatic logic [COORD_W-1:0] bound(input logic signed [SW-1:0] s,
                                                 input logic signed [SW-1:0] ext);
        logic signed [SW-1:0] r;
        r = s;
        if (s[SW-1]) begin
            r = (WRAP != 0) ? s + ext : '0;
        end else if (s >= ext) begin
            r = (WRAP != 0) ? s - ext : ext - {{(SW-1){1'b0}}, 1'b1};
        end
        return r[COORD_W-1:0];
    endfunction

    // -(-128) does not fit in 8 bits, so it saturates to +127.
    always_comb begin
        dy_in = mouse_dy;
        if (INVERT_Y != 0) begin
            dy_in = (mouse_dy == 8'h80) ? 8'h7f : 8'(-mouse_dy);
        end
    end

    always_comb begin
        step_x = $signed({{(SW-8){work_dx[7]}}, work_dx}) <<< SHIFT;
        step_y = $signed({{(SW-8){work_dy[7]}}, work_dy}) <<< SHIFT;
        pos_x  = $signed({{(SW-COORD_W){1'b0}}, cur_x});
        pos_y  = $signed({{(SW-COORD_W){1'b0}}, cur_y});
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (report) state_next = SUM;
            SUM:     state_next = BOUND;
            BOUND:   state_next = (pend_flag || report) ? SUM : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur_x     <= '0;
            cur_y     <= '0;
            frame_x   <= '0;
            frame_y   <= '0;
            btn       <= '0;
            btn_q     <= '0;
            btn_press <= '0;
            moved     <= 1'b0;
            work_dx   <= '0;
            work_dy   <= '0;
            pend_dx   <= '0;
            pend_dy   <= '0;
            pend_flag <= 1'b0;
            sum_x     <= '0;
            sum_y     <= '0;
        end else begin
            state     <= state_next;
            moved     <= 1'b0;
            btn_q     <= btn;
            btn_press <= btn & ~btn_q;
            if (report) btn <= mouse_btn;
            // Nonblocking reads give the position from before a same-edge commit.
            if (frame_tick) begin
                frame_x <= cur_x;
                frame_y <= cur_y;
            end
            case (state)
                IDLE: begin
                    if (report) begin
                        work_dx <= mouse_dx;
                        work_dy <= dy_in;
                    end
                end
                SUM: begin
                    sum_x <= pos_x + step_x;
                    sum_y <= pos_y + step_y;
                    if (report) begin
                        pend_dx   <= sat_add(pend_dx, mouse_dx);
                        pend_dy   <= sat_add(pend_dy, dy_in);
                        pend_flag <= 1'b1;
                    end
                end
                BOUND: begin
                    cur_x <= bound(sum_x, EXT_X);
                    cur_y <= bound(sum_y, EXT_Y);
                    moved <= 1'b1;
                    // Pending deltas move to the working set; a report in this
                    // same cycle starts a fresh pending value for a later pass.
                    if (pend_flag) begin
                        work_dx   <= pend_dx;
                        work_dy   <= pend_dy;
                        pend_dx   <= report ? mouse_dx : 8'h00;
                        pend_dy   <= report ? dy_in : 8'h00;
                        pend_flag <= report;
                    end else if (report) begin
                        work_dx <= mouse_dx;
                        work_dy <= dy_in;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
